jump_motion: RTL

//  Executes the player jump requested by the game controller: the responder side of the jump_En/jump_fin handshake.

---
 rtl/jump_pkg.sv | 30 +++
 rtl/jump_parabola.sv | 37 +++
 rtl/jump_motion.sv | 139 +++++++++++++
 3 files changed

// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - state encoding, default widths and arc constants for jump_motion
package jump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_FLY,
    S_DONE,
    S_HOLD
  } jump_state_t;

  localparam int DEF_PW          = 10;
  localparam int DEF_XW          = 10;
  localparam int DEF_YW          = 8;
  localparam int DEF_DIST_SHIFT  = 2;
  localparam int DEF_MAX_DIST    = 200;
  localparam int DEF_FRAMES_LOG2 = 5;
  localparam int DEF_JUMP_H      = 64;

  // Flight length in ticks.
  function automatic int frames_n(input int fl);
    return 1 << fl;
  endfunction

  // f*(N-f) peaks at N*N/4, so this shift normalises the apex to JUMP_H.
  function automatic int y_shift(input int fl);
    return 2 * fl - 2;
  endfunction

endpackage

// File: rtl/jump_parabola.sv
// rtl/jump_parabola.sv - registered parabolic height y = JUMP_H*f*(N-f) scaled to the apex
module jump_parabola
  import jump_pkg::*;
#(
  parameter int YW          = DEF_YW,
  parameter int FRAMES_LOG2 = DEF_FRAMES_LOG2,
  parameter int JUMP_H      = DEF_JUMP_H
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [FRAMES_LOG2:0] f,
  output logic [YW-1:0]        y_off
);

  localparam int FW  = FRAMES_LOG2 + 1;
  localparam int N   = frames_n(FRAMES_LOG2);
  localparam int PRW = YW + 2 * FW + 1;

  logic [FW-1:0]  f_rem;
  logic [PRW-1:0] prod;

  // Full-width product; only the final shift narrows the result.
  assign f_rem = FW'(N) - f;
  assign prod  = PRW'(JUMP_H) * PRW'(f) * PRW'(f_rem);

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_off <= '0;
    end else if (clr) begin
      y_off <= '0;
    end else begin
      y_off <= YW'(prod >> y_shift(FRAMES_LOG2));
    end
  end

endmodule

// File: rtl/jump_motion.sv
// rtl/jump_motion.sv - jump responder: press-to-distance, parabolic arc, landing pulse
// Optional sprite spin phase enabled by defining JUMP_MOTION_SPIN_EN.
module jump_motion
  import jump_pkg::*;
#(
  parameter int PW          = DEF_PW,
  parameter int XW          = DEF_XW,
  parameter int YW          = DEF_YW,
  parameter int DIST_SHIFT  = DEF_DIST_SHIFT,
  parameter int MAX_DIST    = DEF_MAX_DIST,
  parameter int FRAMES_LOG2 = DEF_FRAMES_LOG2,
  parameter int JUMP_H      = DEF_JUMP_H
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_En,
  input  logic [PW-1:0] press_cnt,
  input  logic          tick,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic          busy,
  output logic          jump_fin,
  output logic [XW-1:0] land_x,
  output logic [2:0]    spin_phase
);

  localparam int N  = frames_n(FRAMES_LOG2);
  localparam int FW = FRAMES_LOG2 + 1;
  localparam int AW = XW + FRAMES_LOG2;

  jump_state_t   state, state_n;
  logic [FW-1:0] f, f_n;
  logic [AW-1:0] acc;
  logic [XW-1:0] d;
  logic [PW-1:0] dist_raw;
  logic [XW-1:0] dist_clamped;
  logic          clr;
  logic          fly_tick;

  assign dist_raw     = press_cnt >> DIST_SHIFT;
  assign dist_clamped = (int'(dist_raw) > MAX_DIST) ? XW'(MAX_DIST) : XW'(dist_raw);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // clr zeroes the arc both on a fresh launch and when the controller aborts.
  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    fly_tick = 1'b0;
    case (state)
      S_IDLE: begin
        if (jump_En) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        clr     = 1'b1;
        state_n = jump_En ? S_FLY : S_IDLE;
      end
      S_FLY: begin
        if (!jump_En) begin
          clr     = 1'b1;
          state_n = S_IDLE;
        end else if (tick) begin
          fly_tick = 1'b1;
          if (f == FW'(N - 1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (!jump_En) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign f_n = clr ? '0 : (fly_tick ? f + FW'(1) : f);

  always_ff @(posedge clk) begin
    if (!rst) begin
      f        <= '0;
      acc      <= '0;
      d        <= '0;
      x_off    <= '0;
      busy     <= 1'b0;
      jump_fin <= 1'b0;
      land_x   <= '0;
    end else begin
      f        <= f_n;
      busy     <= (state_n == S_LAUNCH) || (state_n == S_FLY) || (state_n == S_DONE);
      jump_fin <= (state_n == S_DONE);
      if (state_n == S_DONE) land_x <= d;
      if (state == S_LAUNCH) d <= dist_clamped;
      // x_off trails acc by one cycle, matching the parabola register.
      if (clr) begin
        acc   <= '0;
        x_off <= '0;
      end else begin
        if (fly_tick) acc <= acc + AW'(d);
        if ((state == S_FLY) || (state == S_DONE)) x_off <= XW'(acc >> FRAMES_LOG2);
      end
    end
  end

  jump_parabola #(
    .YW         (YW),
    .FRAMES_LOG2(FRAMES_LOG2),
    .JUMP_H     (JUMP_H)
  ) u_parabola (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .f    (f),
    .y_off(y_off)
  );

`ifdef JUMP_MOTION_SPIN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      spin_phase <= 3'd0;
    end else if (state_n == S_FLY) begin
      spin_phase <= 3'(f_n >> (FRAMES_LOG2 - 3));
    end else begin
      spin_phase <= 3'd0;
    end
  end
`else
  assign spin_phase = 3'd0;
`endif

endmodule
